// File: rtl/pipe_hazard_fwd_unit_if.sv
// ID-stage hazard/forwarding bus: decoded ID instruction and pipeline controls in,
// operand-forward selects, load-use stall and stall counter out.
interface pipe_hazard_fwd_unit_if #(
    parameter int unsigned RN_W  = 5,
    parameter int unsigned SEL_W = 2
);
    logic             pipe_en;
    logic             flush;
    logic             id_valid;
    logic [RN_W-1:0]  id_rs;
    logic [RN_W-1:0]  id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wreg;
    logic             id_m2reg;
    logic [RN_W-1:0]  id_rn;
    logic             cnt_clr;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic [15:0]      stall_cnt;

    modport master (
        output pipe_en, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rn, cnt_clr,
        input  stall, fwd_a, fwd_b, stall_cnt
    );

    modport slave (
        input  pipe_en, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rn, cnt_clr,
        output stall, fwd_a, fwd_b, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_fwd_unit.sv
// ID-stage hazard and forwarding unit: tracks in-flight destinations in a shift
// scoreboard, drives rs/rt forward selects, the load-use stall and a stall counter.
module pipe_hazard_fwd_unit #(
    parameter int unsigned RN_W     = 5,
    parameter int unsigned FWD_STG  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    pipe_hazard_fwd_unit_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic            v;
        logic [RN_W-1:0] rn;
        logic            ld;
    } slot_t;

    slot_t            slot_q [FWD_STG];
    slot_t            slot0_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             hit_a, hit_b, rdy_a, rdy_b;
    logic [SEL_W-1:0] sel_a, sel_b;
    logic             live, rdy, hazard_c, stall_c;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        sel_a = '0;
        sel_b = '0;
        live  = 1'b0;
        rdy   = 1'b1;
        for (int k = int'(FWD_STG) - 1; k >= 0; k--) begin
            live = slot_q[k].v && (slot_q[k].rn != '0);
            rdy  = !slot_q[k].ld || (k >= int'(LOAD_LAT));
            if (live && bus.id_use_rs && (slot_q[k].rn == bus.id_rs)) begin
                hit_a = 1'b1;
                rdy_a = rdy;
                sel_a = SEL_W'(k + 1);
            end
            if (live && bus.id_use_rt && (slot_q[k].rn == bus.id_rt)) begin
                hit_b = 1'b1;
                rdy_b = rdy;
                sel_b = SEL_W'(k + 1);
            end
        end
    end

    assign hazard_c = (hit_a && !rdy_a) || (hit_b && !rdy_b);
    assign stall_c  = hazard_c && bus.id_valid && !bus.flush;

    assign bus.stall     = stall_c;
    assign bus.fwd_a     = (hit_a && rdy_a) ? sel_a : '0;
    assign bus.fwd_b     = (hit_b && rdy_b) ? sel_b : '0;
    assign bus.stall_cnt = stall_cnt_q;

    // Stalled, squashed or empty ID slots enter the scoreboard as bubbles.
    always_comb begin
        slot0_d = '0;
        if (!(stall_c || bus.flush || !bus.id_valid)) begin
            slot0_d.v  = bus.id_wreg;
            slot0_d.rn = bus.id_rn;
            slot0_d.ld = bus.id_m2reg;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < int'(FWD_STG); k++) slot_q[k] <= '0;
        end else if (bus.pipe_en) begin
            slot_q[0] <= slot0_d;
            for (int k = 1; k < int'(FWD_STG); k++) slot_q[k] <= slot_q[k-1];
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_q <= '0;
        end else if (bus.pipe_en && stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
endmodule
